// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: sequences EA/MAR datapath and memory handshake for LC-3 LD/LDI/LDR/ST/STI/STR/LEA/TRAP.
// Optional feature macro MEM_TIMEOUT_EN: abort an unanswered memory request after TIMEOUT_CYCLES cycles.
module mem_access_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic [15:0] store_data,
    output logic [1:0]  ir_mux,
    output logic        reg_mux,
    output logic        mar_sel,
    output logic        gate_mar,
    input  logic [15:0] mar,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic        wb_valid,
    output logic        pc_load,
    output logic [15:0] wb_data,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, CALC, IND, ACC, FIN} state_t;

    state_t      st, nxt;
    logic [3:0]  op_q;
    logic [15:0] store_q, addr_q, wb_q, addr_d, wb_d;
    logic        wbv_q, pcl_q, err_q, wbv_n, pcl_n, err_n, addr_en, wb_en, tmo, active;
    logic        is_load, is_store, is_pcrel, is_base, is_trap, is_lea, is_ind;

    function automatic logic legal(input logic [3:0] o);
        return o inside {4'b0010, 4'b1010, 4'b0110, 4'b0011, 4'b1011, 4'b0111, 4'b1110, 4'b1111};
    endfunction

    assign is_load  = op_q inside {4'b0010, 4'b1010, 4'b0110};
    assign is_store = op_q inside {4'b0011, 4'b1011, 4'b0111};
    assign is_pcrel = op_q inside {4'b0010, 4'b1010, 4'b0011, 4'b1011, 4'b1110};
    assign is_base  = op_q inside {4'b0110, 4'b0111};
    assign is_ind   = op_q inside {4'b1010, 4'b1011, 4'b1111};
    assign is_trap  = op_q == 4'b1111;
    assign is_lea   = op_q == 4'b1110;

    // Selects are only meaningful while an operation is in flight; otherwise they sit at reset values.
    assign active    = st == CALC || st == IND || st == ACC;
    assign ir_mux    = !active ? 2'b11 : is_pcrel ? 2'b01 : is_base ? 2'b10 : 2'b11;
    assign reg_mux   = active && is_pcrel;
    assign mar_sel   = !(active && is_trap);
    assign gate_mar  = st == CALC;
    assign mem_req   = st == IND || st == ACC;
    assign mem_we    = st == ACC && is_store;
    assign mem_addr  = mem_req ? addr_q : 16'h0;
    assign mem_wdata = mem_we ? store_q : 16'h0;
    assign busy      = st != IDLE;
    assign done      = st == FIN;
    assign wb_valid  = wbv_q;
    assign pc_load   = pcl_q;
    assign err       = err_q;
    assign wb_data   = wb_q;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt;
    assign tmo = mem_req && !mem_ready && cnt == CW'(TIMEOUT_CYCLES - 1);
    // Count unanswered request cycles; restarts whenever a request ends or a new one begins.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= (mem_req && !mem_ready && nxt == st) ? cnt + CW'(1) : '0;
`else
    assign tmo = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) st <= IDLE;
        else        st <= nxt;

    // Next state plus the capture strobes and completion flags for the FIN cycle.
    always_comb begin
        nxt     = st;
        wbv_n   = 1'b0;
        pcl_n   = 1'b0;
        err_n   = 1'b0;
        addr_en = 1'b0;
        addr_d  = mar;
        wb_en   = 1'b0;
        wb_d    = mem_rdata;
        case (st)
            IDLE: if (start) begin
                nxt   = legal(opcode) ? CALC : FIN;
                err_n = !legal(opcode);
            end
            CALC: begin
                addr_en = 1'b1;
                nxt     = is_lea ? FIN : is_ind ? IND : ACC;
                wbv_n   = is_lea;
                wb_en   = is_lea;
                wb_d    = mar;
            end
            IND: if (mem_ready) begin
                addr_en = 1'b1;
                addr_d  = mem_rdata;
                nxt     = is_trap ? FIN : ACC;
                pcl_n   = is_trap;
                wb_en   = is_trap;
            end else if (tmo) begin
                nxt   = FIN;
                err_n = 1'b1;
            end
            ACC: if (mem_ready) begin
                nxt   = FIN;
                wbv_n = is_load;
                wb_en = is_load;
            end else if (tmo) begin
                nxt   = FIN;
                err_n = 1'b1;
            end
            default: nxt = IDLE;
        endcase
    end

    // Operand latches, address/result registers and one-cycle FIN flags.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            op_q    <= '0;
            store_q <= '0;
            addr_q  <= '0;
            wb_q    <= '0;
            wbv_q   <= 1'b0;
            pcl_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (st == IDLE && start) begin
                op_q    <= opcode;
                store_q <= store_data;
            end
            if (addr_en) addr_q <= addr_d;
            if (wb_en)   wb_q <= wb_d;
            wbv_q <= wbv_n;
            pcl_q <= pcl_n;
            err_q <= err_n;
        end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: directed self-checking bench for mem_access_sequencer.
module tb_mem_access_sequencer;
    localparam int TO = 5;
    localparam logic [59:0] RST = {2'b11, 1'b0, 1'b1, 56'b0};

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [3:0]  opcode = '0;
    logic [15:0] store_data = '0, mar = '0, mem_rdata;
    logic [1:0]  ir_mux;
    logic        reg_mux, mar_sel, gate_mar, mem_req, mem_we, mem_ready;
    logic        wb_valid, pc_load, busy, done, err;
    logic [15:0] mem_addr, mem_wdata, wb_data;
    logic [59:0] all_out;

    int          checks = 0, errors = 0, waits = 0, wcnt = 0;
    logic        ready_en = 1'b1, force_ready = 1'b0;
    logic [15:0] ma = '0, md = '0;

    mem_access_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .store_data(store_data),
        .ir_mux(ir_mux), .reg_mux(reg_mux), .mar_sel(mar_sel), .gate_mar(gate_mar), .mar(mar),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .pc_load(pc_load),
        .wb_data(wb_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign all_out   = {ir_mux, reg_mux, mar_sel, gate_mar, mem_req, mem_we, mem_addr, mem_wdata,
                        wb_valid, pc_load, wb_data, busy, done, err};
    assign mem_rdata = (mem_addr == ma) ? md : 16'h0;
    assign mem_ready = force_ready | (ready_en & mem_req & (wcnt == waits));

    always @(posedge clk) wcnt <= (!mem_req || mem_ready) ? 0 : wcnt + 1;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic launch(input logic [3:0] op, input logic [15:0] m, input logic [15:0] sd);
        start = 1'b1; opcode = op; mar = m; store_data = sd;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        checks++; if (all_out !== RST) begin errors++; $display("FAIL reset got %h want %h", all_out, RST); end
        rst_n = 1'b1;
        cyc();
        checks++; if (all_out !== RST) begin errors++; $display("FAIL reset_idle got %h want %h", all_out, RST); end
    endtask

    task automatic test_ld();
        waits = 0; ma = 16'h3005; md = 16'hBEEF; force_ready = 1'b1;
        launch(4'b0010, 16'h3005, 16'h0);
        checks++; if ({gate_mar, mem_req, busy, ir_mux, reg_mux, mar_sel} !== {1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1})
            begin errors++; $display("FAIL ld_calc got %b", {gate_mar, mem_req, busy, ir_mux, reg_mux, mar_sel}); end
        cyc(); force_ready = 1'b0;
        checks++; if ({gate_mar, mem_req, mem_we, done, mem_addr} !== {4'b0100, 16'h3005})
            begin errors++; $display("FAIL ld_acc got %h want %h", {gate_mar, mem_req, mem_we, done, mem_addr}, {4'b0100, 16'h3005}); end
        cyc();
        checks++; if ({wb_valid, done, err, pc_load, mem_req, ir_mux, reg_mux, mar_sel, wb_data} !== {5'b11000, 2'b11, 1'b0, 1'b1, 16'hBEEF})
            begin errors++; $display("FAIL ld_fin got %h wb %h want wb beef", {wb_valid, done, err, pc_load, mem_req}, wb_data); end
        cyc();
        checks++; if ({busy, done, wb_valid} !== 3'b000) begin errors++; $display("FAIL ld_idle got %b want 000", {busy, done, wb_valid}); end
    endtask

    task automatic test_sti();
        waits = 2; ma = 16'h4000; md = 16'h5123;
        launch(4'b1011, 16'h4000, 16'h00AA);
        checks++; if ({gate_mar, ir_mux, reg_mux} !== 4'b1011) begin errors++; $display("FAIL sti_calc got %b want 1011", {gate_mar, ir_mux, reg_mux}); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if ({mem_req, mem_we, gate_mar, done, mem_addr} !== {4'b1000, 16'h4000})
                begin errors++; $display("FAIL sti_ind%0d got %h want %h", i, {mem_req, mem_we, gate_mar, done, mem_addr}, {4'b1000, 16'h4000}); end
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h5123, 16'h00AA})
                begin errors++; $display("FAIL sti_acc%0d got %h want %h", i, {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h5123, 16'h00AA}); end
        end
        cyc();
        checks++; if ({done, wb_valid, pc_load, err, mem_req} !== 5'b10000) begin errors++; $display("FAIL sti_fin got %b want 10000", {done, wb_valid, pc_load, err, mem_req}); end
        cyc();
    endtask

    task automatic test_lea();
        waits = 0;
        launch(4'b1110, 16'hFFFE, 16'h0);
        checks++; if ({gate_mar, ir_mux, reg_mux, mar_sel, mem_req} !== 6'b101110) begin errors++; $display("FAIL lea_calc got %b want 101110", {gate_mar, ir_mux, reg_mux, mar_sel, mem_req}); end
        cyc();
        checks++; if ({done, wb_valid, mem_req, err, wb_data} !== {4'b1100, 16'hFFFE})
            begin errors++; $display("FAIL lea_fin got %h want %h", {done, wb_valid, mem_req, err, wb_data}, {4'b1100, 16'hFFFE}); end
        cyc();
        checks++; if ({busy, mem_req} !== 2'b00) begin errors++; $display("FAIL lea_idle got %b want 00", {busy, mem_req}); end
    endtask

    task automatic test_trap();
        waits = 0; ma = 16'h0025; md = 16'h0520;
        launch(4'b1111, 16'h0025, 16'h0);
        checks++; if ({gate_mar, ir_mux, reg_mux, mar_sel} !== 5'b11100) begin errors++; $display("FAIL trap_calc got %b want 11100", {gate_mar, ir_mux, reg_mux, mar_sel}); end
        cyc();
        checks++; if ({mem_req, mem_we, mar_sel, mem_addr} !== {3'b100, 16'h0025})
            begin errors++; $display("FAIL trap_ind got %h want %h", {mem_req, mem_we, mar_sel, mem_addr}, {3'b100, 16'h0025}); end
        cyc();
        checks++; if ({pc_load, wb_valid, done, err, wb_data} !== {4'b1010, 16'h0520})
            begin errors++; $display("FAIL trap_fin got %h want %h", {pc_load, wb_valid, done, err, wb_data}, {4'b1010, 16'h0520}); end
        cyc();
    endtask

    task automatic test_illegal();
        launch(4'b0000, 16'h1111, 16'h0);
        checks++; if ({done, err, busy, gate_mar, mem_req} !== 5'b11100) begin errors++; $display("FAIL ill_fin got %b want 11100", {done, err, busy, gate_mar, mem_req}); end
        cyc();
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL ill_idle got %b want 000", {busy, done, err}); end
    endtask

    task automatic test_back_to_back();
        waits = 1; ma = 16'h1234; md = 16'h7777;
        launch(4'b0110, 16'h1234, 16'h0);
        checks++; if ({ir_mux, reg_mux, mar_sel} !== 4'b1001) begin errors++; $display("FAIL ldr_calc got %b want 1001", {ir_mux, reg_mux, mar_sel}); end
        cyc();
        checks++; if ({mem_req, mem_addr} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL ldr_acc got %h", {mem_req, mem_addr}); end
        start = 1'b1; opcode = 4'b0000;
        cyc();
        start = 1'b0; opcode = 4'b0110;
        checks++; if ({mem_req, err, done, mem_addr} !== {3'b100, 16'h1234}) begin errors++; $display("FAIL ldr_wait got %h", {mem_req, err, done, mem_addr}); end
        cyc();
        checks++; if ({done, wb_valid, err, wb_data} !== {3'b110, 16'h7777})
            begin errors++; $display("FAIL ldr_fin got %h want %h", {done, wb_valid, err, wb_data}, {3'b110, 16'h7777}); end
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ldr_idle got %b want 0", busy); end
        launch(4'b1110, 16'h0042, 16'h0);
        checks++; if (gate_mar !== 1'b1) begin errors++; $display("FAIL b2b_calc got %b want 1", gate_mar); end
        cyc();
        checks++; if ({done, wb_valid, wb_data} !== {2'b11, 16'h0042}) begin errors++; $display("FAIL b2b_fin got %h", {done, wb_valid, wb_data}); end
        cyc();
    endtask

    task automatic test_reset_mid();
        ready_en = 1'b0; ma = 16'h2222; md = 16'h9999;
        launch(4'b0010, 16'h2222, 16'h0);
        cyc();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre got %b want 1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (all_out !== RST) begin errors++; $display("FAIL rst_mid got %h want %h", all_out, RST); end
        cyc();
        rst_n = 1'b1; ready_en = 1'b1;
        cyc();
        checks++; if (all_out !== RST) begin errors++; $display("FAIL rst_after got %h want %h", all_out, RST); end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        ready_en = 1'b0;
        launch(4'b0010, 16'h3333, 16'h0);
        for (int i = 0; i < 20 && !done; i++) begin
            cyc();
            if (mem_req) n++;
        end
        checks++; if ({done, err, wb_valid, pc_load, mem_req} !== 5'b11000) begin errors++; $display("FAIL tmo_fin got %b want 11000", {done, err, wb_valid, pc_load, mem_req}); end
        checks++; if (n !== TO) begin errors++; $display("FAIL tmo_cycles got %0d want %0d", n, TO); end
        ready_en = 1'b1;
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_ld();
        test_sti();
        test_lea();
        test_trap();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
